// File: rtl/instruction_decode_stage_if.sv
// Upstream instruction handshake, downstream decoded-entry handshake and status.
// The master drives instructions and accepts entries; the slave is the decode stage.
interface instruction_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [6:0]       out_opcode;
  logic [4:0]       out_rd;
  logic [2:0]       out_func3;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [6:0]       out_func7;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [XLEN-1:0]  out_pc;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_count;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_func3, out_rs1, out_rs2,
           out_func7, out_imm, out_fmt, out_pc, out_illegal, illegal_count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_func3, out_rs1, out_rs2,
           out_func7, out_imm, out_fmt, out_pc, out_illegal, illegal_count
  );
endinterface

// File: rtl/instruction_decode_stage.sv
// RV32/RV64 decode stage: decodes at push and buffers entries in a DEPTH-slot FIFO.
// Handshakes: a transfer happens on a rising edge where valid && ready; ready never depends on valid.
module instruction_decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  instruction_decode_stage_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      func3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      func7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           dec;
  entry_t           head;
  logic [31:0]      imm32;
  logic [2:0]       fmt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [CNT_W-1:0] illegal_count;
  logic             in_ready;
  logic             out_valid;
  logic             push;
  logic             pop;

  assign in_ready  = (count < (PTR_W+1)'(DEPTH));
  assign out_valid = (count != '0);
  // flush wins over both handshakes so a flushed cycle changes nothing but the reset of the buffer
  assign push      = bus.in_valid && in_ready && !bus.flush;
  assign pop       = out_valid && bus.out_ready && !bus.flush;

  always_comb begin
    imm32 = '0;
    fmt   = FMT_ILL;
    case (bus.in_instr[6:0])
      7'b0110011: fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        fmt   = FMT_I;
        imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
      end
      7'b0100011: begin
        fmt   = FMT_S;
        imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
      end
      7'b1100011: begin
        fmt   = FMT_B;
        imm32 = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                 bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        fmt   = FMT_U;
        imm32 = {bus.in_instr[31:12], 12'h000};
      end
      7'b1101111: begin
        fmt   = FMT_J;
        imm32 = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                 bus.in_instr[20], bus.in_instr[30:21], 1'b0};
      end
      default: fmt = FMT_ILL;
    endcase
  end

  // Every legal opcode ends in 2'b11, so a bad low pair already lands in the default arm.
  always_comb begin
    dec         = '0;
    dec.opcode  = bus.in_instr[6:0];
    dec.rd      = bus.in_instr[11:7];
    dec.func3   = bus.in_instr[14:12];
    dec.rs1     = bus.in_instr[19:15];
    dec.rs2     = bus.in_instr[24:20];
    dec.func7   = bus.in_instr[31:25];
    dec.imm     = XLEN'($signed(imm32));
    dec.fmt     = fmt;
    dec.pc      = bus.in_pc;
    dec.illegal = (fmt == FMT_ILL);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_count <= '0;
    end else if (push && dec.illegal && (illegal_count != {CNT_W{1'b1}})) begin
      illegal_count <= illegal_count + CNT_W'(1);
    end
  end

  always_comb begin
    head = '0;
    if (out_valid) head = mem[rd_ptr];
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid;
  assign bus.out_opcode    = head.opcode;
  assign bus.out_rd        = head.rd;
  assign bus.out_func3     = head.func3;
  assign bus.out_rs1       = head.rs1;
  assign bus.out_rs2       = head.rs2;
  assign bus.out_func7     = head.func7;
  assign bus.out_imm       = head.imm;
  assign bus.out_fmt       = head.fmt;
  assign bus.out_pc        = head.pc;
  assign bus.out_illegal   = head.illegal;
  assign bus.illegal_count = illegal_count;
endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench: a default RV32 instance and an XLEN=64 / CNT_W=2 instance share clock and reset.
module tb_instruction_decode_stage;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  instruction_decode_stage_if #(.XLEN(32), .CNT_W(16)) bus32 ();
  instruction_decode_stage_if #(.XLEN(64), .CNT_W(2))  bus64 ();

  instruction_decode_stage #(.XLEN(32), .DEPTH(2), .CNT_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus32.slave)
  );
  instruction_decode_stage #(.XLEN(64), .DEPTH(2), .CNT_W(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(bus64.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic rdy, input logic fl);
    bus32.in_valid  = v;
    bus32.in_instr  = instr;
    bus32.in_pc     = pc;
    bus32.out_ready = rdy;
    bus32.flush     = fl;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive32(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.in_pc = '0;
    bus64.out_ready = 1'b0; bus64.flush = 1'b0;
    #1;
    check("reset_out_valid", 64'(bus32.out_valid), 64'd0);
    check("reset_in_ready", 64'(bus32.in_ready), 64'd1);
    check("reset_illegal_count", 64'(bus32.illegal_count), 64'd0);
    check("reset_out_pc", 64'(bus32.out_pc), 64'd0);
    #11 rst_n = 1'b1;
    @(negedge clk);

    // addi x1, x0, 5
    drive32(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
    step();
    check("addi_valid", 64'(bus32.out_valid), 64'd1);
    check("addi_fmt", 64'(bus32.out_fmt), 64'd1);
    check("addi_rd", 64'(bus32.out_rd), 64'd1);
    check("addi_rs1", 64'(bus32.out_rs1), 64'd0);
    check("addi_imm", 64'(bus32.out_imm), 64'h5);
    check("addi_pc", 64'(bus32.out_pc), 64'h100);
    check("addi_opcode", 64'(bus32.out_opcode), 64'h13);

    // beq x0, x0, -4 pushed while addi pops
    drive32(1'b1, 32'hFE000EE3, 32'h104, 1'b1, 1'b0);
    step();
    check("beq_fmt", 64'(bus32.out_fmt), 64'd3);
    check("beq_imm", 64'(bus32.out_imm), 64'hFFFFFFFC);
    check("beq_rs1", 64'(bus32.out_rs1), 64'd0);
    check("beq_rs2", 64'(bus32.out_rs2), 64'd0);
    check("beq_pc", 64'(bus32.out_pc), 64'h104);
    drive32(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check("drain_valid", 64'(bus32.out_valid), 64'd0);
    check("drain_imm_zero", 64'(bus32.out_imm), 64'd0);
    check("drain_fmt_zero", 64'(bus32.out_fmt), 64'd0);

    // backpressure: A (add), B (addi x2,x0,1), C (addi x3,x0,2) with DEPTH=2
    drive32(1'b1, 32'h00000033, 32'h200, 1'b0, 1'b0);
    step();
    check("bp_ready_after_1", 64'(bus32.in_ready), 64'd1);
    drive32(1'b1, 32'h00100113, 32'h204, 1'b0, 1'b0);
    step();
    check("bp_ready_after_2", 64'(bus32.in_ready), 64'd0);
    drive32(1'b1, 32'h00200193, 32'h208, 1'b0, 1'b0);
    step();
    check("bp_still_full", 64'(bus32.in_ready), 64'd0);
    check("bp_head_a_pc", 64'(bus32.out_pc), 64'h200);
    check("bp_head_a_fmt", 64'(bus32.out_fmt), 64'd0);
    drive32(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check("bp_head_b_pc", 64'(bus32.out_pc), 64'h204);
    check("bp_head_b_rd", 64'(bus32.out_rd), 64'd2);
    check("bp_head_b_imm", 64'(bus32.out_imm), 64'h1);
    step();
    check("bp_c_dropped", 64'(bus32.out_valid), 64'd0);

    // illegal words
    drive32(1'b1, 32'h00000000, 32'h300, 1'b0, 1'b0);
    step();
    check("ill0_illegal", 64'(bus32.out_illegal), 64'd1);
    check("ill0_fmt", 64'(bus32.out_fmt), 64'd7);
    check("ill0_imm", 64'(bus32.out_imm), 64'd0);
    check("ill0_count", 64'(bus32.illegal_count), 64'd1);
    drive32(1'b1, 32'hFFFFFFFF, 32'h304, 1'b0, 1'b0);
    step();
    check("ill1_count", 64'(bus32.illegal_count), 64'd2);
    drive32(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check("ill1_pc", 64'(bus32.out_pc), 64'h304);
    check("ill1_illegal", 64'(bus32.out_illegal), 64'd1);
    check("ill1_fmt", 64'(bus32.out_fmt), 64'd7);
    check("ill1_imm", 64'(bus32.out_imm), 64'd0);
    step();
    check("ill_drain", 64'(bus32.out_valid), 64'd0);

    // flush with a full buffer and an incoming instruction
    drive32(1'b1, 32'h00500093, 32'h400, 1'b0, 1'b0);
    step();
    drive32(1'b1, 32'h00000000, 32'h404, 1'b0, 1'b0);
    step();
    check("pre_flush_count", 64'(bus32.illegal_count), 64'd3);
    drive32(1'b1, 32'hFFFFFFFF, 32'h408, 1'b0, 1'b1);
    step();
    check("flush_full_valid", 64'(bus32.out_valid), 64'd0);
    check("flush_full_ready", 64'(bus32.in_ready), 64'd1);
    check("flush_full_illcnt", 64'(bus32.illegal_count), 64'd3);
    drive32(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    check("flush_full_dropped", 64'(bus32.out_valid), 64'd0);

    // flush with room left: the incoming illegal word must still be blocked
    drive32(1'b1, 32'h00000093, 32'h500, 1'b0, 1'b0);
    step();
    drive32(1'b1, 32'hFFFFFFFF, 32'h504, 1'b0, 1'b1);
    step();
    check("flush_one_valid", 64'(bus32.out_valid), 64'd0);
    check("flush_one_illcnt", 64'(bus32.illegal_count), 64'd3);
    drive32(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    check("flush_one_dropped", 64'(bus32.out_valid), 64'd0);

    // asynchronous reset between edges with one entry buffered
    drive32(1'b1, 32'h00500093, 32'h600, 1'b0, 1'b0);
    step();
    drive32(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("pre_rst_valid", 64'(bus32.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus32.out_valid), 64'd0);
    check("async_rst_ready", 64'(bus32.in_ready), 64'd1);
    check("async_rst_pc", 64'(bus32.out_pc), 64'd0);
    check("async_rst_illcnt", 64'(bus32.illegal_count), 64'd0);
    #1 rst_n = 1'b1;
    drive32(1'b1, 32'h00700213, 32'h700, 1'b0, 1'b0);
    step();
    check("post_rst_valid", 64'(bus32.out_valid), 64'd1);
    check("post_rst_pc", 64'(bus32.out_pc), 64'h700);
    check("post_rst_imm", 64'(bus32.out_imm), 64'h7);
    drive32(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // XLEN=64: lui x5, 0x80000 sign-extends to 64 bits
    bus64.in_valid = 1'b1; bus64.in_instr = 32'h800002B7;
    bus64.in_pc = 64'h8000_0000_0000_1000; bus64.out_ready = 1'b0;
    step();
    check("lui64_fmt", 64'(bus64.out_fmt), 64'd4);
    check("lui64_rd", 64'(bus64.out_rd), 64'd5);
    check("lui64_imm", bus64.out_imm, 64'hFFFFFFFF80000000);
    check("lui64_pc", bus64.out_pc, 64'h8000_0000_0000_1000);

    // CNT_W=2 saturation with the buffer draining each cycle
    bus64.in_instr = 32'h00000000; bus64.in_pc = 64'h2000; bus64.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 1) check("sat_after_2", 64'(bus64.illegal_count), 64'd2);
    end
    check("sat_after_5", 64'(bus64.illegal_count), 64'd3);
    check("sat_head_illegal", 64'(bus64.out_illegal), 64'd1);
    bus64.in_valid = 1'b0;
    step();
    step();
    check("sat_drain", 64'(bus64.out_valid), 64'd0);
    check("sat_hold", 64'(bus64.illegal_count), 64'd3);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
